// File: rtl/mvm_lanes.sv
// mvm_lanes: signed matrix-vector multiplier y = A*x with P parallel MAC lanes.
//
// A (K x K) and x (K) are streamed in over s_valid/s_ready/s_data. A start
// command computes y in K/P passes of K+3 cycles each. The K results are
// then streamed out over m_valid/m_ready/m_data/m_last, with backpressure.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   load_matrix           command: load A row-major (sampled in IDLE only)
//   load_vector           command: load x (sampled in IDLE only)
//   start                 command: compute y (sampled in IDLE only)
//   s_valid/s_ready/s_data  input element stream (signed, B bits)
//   m_valid/m_ready/m_data  output element stream (signed, OUT_W bits)
//   m_last                marks y[K-1]
//   busy                  high whenever not IDLE
//   done                  one-cycle pulse after y[K-1] is accepted
//
// Build option: define MVM_SAT_EN to saturate the accumulator-to-output
// conversion instead of wrapping.

module mvm_lanes #(
  parameter int K     = 8,
  parameter int P     = 2,
  parameter int B     = 8,
  parameter int OUT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_matrix,
  input  logic                    load_vector,
  input  logic                    start,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic signed [B-1:0]     s_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic signed [OUT_W-1:0] m_data,
  output logic                    m_last,
  output logic                    busy,
  output logic                    done
);

  localparam int ACC_W = 2 * B + $clog2(K);
  localparam int G     = K / P;                    // passes / rows per lane
  localparam int CW    = $clog2(K);
  localparam int GW    = (G > 1) ? $clog2(G) : 1;
  localparam int LW    = (P > 1) ? $clog2(P) : 1;
  localparam int TW    = $clog2(K + 3);
  localparam int AW    = $clog2(G * K);

  localparam logic [TW-1:0] T_K    = TW'(K);
  localparam logic [TW-1:0] T_K1   = TW'(K + 1);
  localparam logic [TW-1:0] T_LAST = TW'(K + 2);

`ifdef MVM_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};
`endif

  function automatic logic signed [OUT_W-1:0] to_out(input logic signed [ACC_W-1:0] a);
`ifdef MVM_SAT_EN
    if (a > SAT_MAX)      return SAT_MAX[OUT_W-1:0];
    else if (a < SAT_MIN) return SAT_MIN[OUT_W-1:0];
    else                  return a[OUT_W-1:0];
`else
    return a[OUT_W-1:0];
`endif
  endfunction

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_X, COMPUTE, OUTPUT} state_t;

  state_t state, state_nx;

  logic [CW-1:0] col_cnt;   // column during loads
  logic [LW-1:0] lane_cnt;  // row mod P during LOAD_A
  logic [GW-1:0] grp_cnt;   // row div P during LOAD_A, pass index in COMPUTE
  logic [TW-1:0] t_cnt;     // cycle within a compute pass
  logic [CW-1:0] out_idx;
  logic [CW-1:0] out_nx;

  logic beat, col_last, lane_last, grp_last, t_last;
  logic issue, prod_en, acc_clr, acc_en, wb;
  logic [AW-1:0] wr_addr, rd_addr;

  logic signed [B-1:0]     x_mem [K];
  logic signed [B-1:0]     x_rd;
  logic signed [OUT_W-1:0] y_mem [K];
  logic signed [OUT_W-1:0] lane_y [P];

  assign s_ready   = (state == LOAD_A) || (state == LOAD_X);
  assign busy      = (state != IDLE);
  assign beat      = s_valid && s_ready;
  assign col_last  = (col_cnt == CW'(K - 1));
  assign lane_last = (lane_cnt == LW'(P - 1));
  assign grp_last  = (grp_cnt == GW'(G - 1));
  assign t_last    = (t_cnt == T_LAST);
  assign out_nx    = out_idx + 1'b1;

  // Pass pipeline: issue (t<K) -> read reg -> product reg -> accumulate.
  assign issue   = (state == COMPUTE) && (t_cnt < T_K);
  assign prod_en = (state == COMPUTE) && (t_cnt != '0) && (t_cnt <= T_K);
  assign acc_clr = (state == COMPUTE) && (t_cnt == '0);
  assign acc_en  = (state == COMPUTE) && (t_cnt >= TW'(2)) && (t_cnt <= T_K1);
  assign wb      = (state == COMPUTE) && t_last;

  assign wr_addr = AW'(int'(grp_cnt) * K + int'(col_cnt));
  assign rd_addr = AW'(int'(grp_cnt) * K + int'(t_cnt));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (load_matrix)      state_nx = LOAD_A;
        else if (load_vector) state_nx = LOAD_X;
        else if (start)       state_nx = COMPUTE;
      end
      LOAD_A:  if (beat && col_last && lane_last && grp_last) state_nx = IDLE;
      LOAD_X:  if (beat && col_last) state_nx = IDLE;
      COMPUTE: if (t_last && grp_last) state_nx = OUTPUT;
      OUTPUT:  if (m_valid && m_ready && m_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_cnt  <= '0;
      lane_cnt <= '0;
      grp_cnt  <= '0;
      t_cnt    <= '0;
    end else begin
      case (state)
        LOAD_A: begin
          if (beat) begin
            col_cnt <= col_last ? '0 : col_cnt + 1'b1;
            if (col_last) begin
              lane_cnt <= lane_last ? '0 : lane_cnt + 1'b1;
              if (lane_last) grp_cnt <= grp_cnt + 1'b1;
            end
          end
        end
        LOAD_X: if (beat) col_cnt <= col_cnt + 1'b1;
        COMPUTE: begin
          t_cnt <= t_last ? '0 : t_cnt + 1'b1;
          if (t_last) grp_cnt <= grp_cnt + 1'b1;
        end
        OUTPUT: ;
        default: begin
          col_cnt  <= '0;
          lane_cnt <= '0;
          grp_cnt  <= '0;
          t_cnt    <= '0;
        end
      endcase
    end
  end

  // Storage and datapath registers are intentionally not reset.
  always_ff @(posedge clk) begin
    if ((state == LOAD_X) && beat) x_mem[col_cnt] <= s_data;
    if (issue) x_rd <= x_mem[t_cnt[CW-1:0]];
  end

  for (genvar l = 0; l < P; l++) begin : g_lane
    logic signed [B-1:0]     a_mem [G * K];  // rows l, l+P, l+2P, ...
    logic signed [B-1:0]     a_rd;
    logic signed [2*B-1:0]   prod;
    logic signed [ACC_W-1:0] acc;

    always_ff @(posedge clk) begin
      if ((state == LOAD_A) && beat && (lane_cnt == LW'(l))) a_mem[wr_addr] <= s_data;
      if (issue)   a_rd <= a_mem[rd_addr];
      if (prod_en) prod <= a_rd * x_rd;
      if (acc_clr)     acc <= '0;
      else if (acc_en) acc <= acc + {{(ACC_W - 2 * B){prod[2*B-1]}}, prod};
    end

    assign lane_y[l] = to_out(acc);
  end

  always_ff @(posedge clk) begin
    if (wb) begin
      for (int unsigned l = 0; l < P; l++) begin
        y_mem[CW'(int'(grp_cnt) * P + int'(l))] <= lane_y[l];
      end
    end
  end

  // The output register is primed one cycle after entering OUTPUT; after
  // that each accepted beat is immediately replaced by the next element.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_data  <= '0;
      done    <= 1'b0;
      out_idx <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        out_idx <= '0;
      end else if (state == OUTPUT) begin
        if (!m_valid) begin
          m_valid <= 1'b1;
          m_data  <= y_mem[out_idx];
          m_last  <= (out_idx == CW'(K - 1));
        end else if (m_ready) begin
          if (m_last) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            done    <= 1'b1;
          end else begin
            out_idx <= out_nx;
            m_data  <= y_mem[out_nx];
            m_last  <= (out_nx == CW'(K - 1));
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mvm_lanes.sv
// Bench for mvm_lanes: a K=4/P=2 instance for the directed scenarios and a
// K=6/P=3 instance checked against an arithmetic reference. Expected output
// beats are queued when a run is started and popped by per-instance monitors.

module tb_mvm_lanes;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic load_matrix = 1'b0, load_vector = 1'b0, start = 1'b0, s_valid = 1'b0, m_ready = 1'b1;
  logic s_ready, m_valid, m_last, busy, done;
  logic signed [7:0]  s_data = '0;
  logic signed [15:0] m_data;

  logic load_matrix_6 = 1'b0, load_vector_6 = 1'b0, start_6 = 1'b0, s_valid_6 = 1'b0, m_ready_6 = 1'b1;
  logic s_ready_6, m_valid_6, m_last_6, busy_6, done_6;
  logic signed [7:0]  s_data_6 = '0;
  logic signed [15:0] m_data_6;

  mvm_lanes #(.K(4), .P(2), .B(8), .OUT_W(16)) u_dut4 (
    .clk(clk), .reset(reset), .load_matrix(load_matrix), .load_vector(load_vector),
    .start(start), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .done(done)
  );

  mvm_lanes #(.K(6), .P(3), .B(8), .OUT_W(16)) u_dut6 (
    .clk(clk), .reset(reset), .load_matrix(load_matrix_6), .load_vector(load_vector_6),
    .start(start_6), .s_valid(s_valid_6), .s_ready(s_ready_6), .s_data(s_data_6),
    .m_valid(m_valid_6), .m_ready(m_ready_6), .m_data(m_data_6), .m_last(m_last_6),
    .busy(busy_6), .done(done_6)
  );

  typedef struct {
    longint data;
    bit     last;
  } beat_t;

  beat_t q4[$];
  beat_t q6[$];

  int n_checks = 0, n_fail = 0, cyc = 0;
  int beats4 = 0, beats6 = 0, dones4 = 0, dones6 = 0;
  int first4 = 0, first6 = 0, t0_4 = 0, t0_6 = 0;
  int accepted4 = 0, accepted6 = 0;
  int stim[64];
  int a6[36];
  int x6[6];

`ifdef MVM_SAT_EN
  localparam longint EXP_POS = 32767;
  localparam longint EXP_NEG = -32768;
`else
  localparam longint EXP_POS = -1020;
  localparam longint EXP_NEG = 512;
`endif

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint conv16(input longint s);
    longint w;
`ifdef MVM_SAT_EN
    if (s > 32767)       w = 32767;
    else if (s < -32768) w = -32768;
    else                 w = s;
`else
    w = s & 64'hFFFF;
    if (w > 32767) w = w - 65536;
`endif
    return w;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor for the K=4 instance: scoreboard pop, hold stability, counters.
  initial begin
    logic pv, hold, pl;
    logic signed [15:0] pd;
    beat_t e;
    pv = 1'b0; hold = 1'b0; pl = 1'b0; pd = '0;
    forever begin
      @(negedge clk);
      if (m_valid && !pv) first4 = cyc;
      if (hold && m_valid) begin
        chk("hold_data4", m_data, pd);
        chk("hold_last4", m_last, pl);
      end
      if (m_valid && m_ready) begin
        if (q4.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL extra_beat4: got beat data %0d, required no beat", m_data);
        end else begin
          e = q4.pop_front();
          chk("data4", m_data, e.data);
          chk("last4", m_last, e.last);
        end
        beats4++;
      end
      if (done) dones4++;
      if (s_valid && s_ready) accepted4++;
      hold = m_valid && !m_ready;
      pd = m_data;
      pl = m_last;
      pv = m_valid;
    end
  end

  // Monitor for the K=6 instance.
  initial begin
    logic pv;
    beat_t e;
    pv = 1'b0;
    forever begin
      @(negedge clk);
      if (m_valid_6 && !pv) first6 = cyc;
      if (m_valid_6 && m_ready_6) begin
        if (q6.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL extra_beat6: got beat data %0d, required no beat", m_data_6);
        end else begin
          e = q6.pop_front();
          chk("data6", m_data_6, e.data);
          chk("last6", m_last_6, e.last);
        end
        beats6++;
      end
      if (done_6) dones6++;
      if (s_valid_6 && s_ready_6) accepted6++;
      pv = m_valid_6;
    end
  end

  task automatic drive_cmd(input bit six, input bit lm, input bit lv, input bit st);
    if (six) begin
      load_matrix_6 = lm; load_vector_6 = lv; start_6 = st;
    end else begin
      load_matrix = lm; load_vector = lv; start = st;
    end
    @(posedge clk); #1;
    load_matrix = 1'b0; load_vector = 1'b0; start = 1'b0;
    load_matrix_6 = 1'b0; load_vector_6 = 1'b0; start_6 = 1'b0;
    if (six) t0_6 = cyc;
    else     t0_4 = cyc;
  endtask

  task automatic send(input bit six, input int n, input bit stall, input bit pulse_start);
    int g;
    bit ok;
    for (int i = 0; i < n; i++) begin
      if (six) begin
        s_valid_6 = 1'b1; s_data_6 = 8'(stim[i]);
      end else begin
        s_valid = 1'b1; s_data = 8'(stim[i]);
        start = pulse_start && (i == 5);
      end
      g = 0;
      ok = 1'b0;
      while (!ok && g < 20) begin
        @(negedge clk);
        ok = six ? s_ready_6 : s_ready;
        chk("busy_load", six ? busy_6 : busy, 1);
        @(posedge clk); #1;
        g++;
      end
      chk("load_handshake", ok, 1);
      s_valid = 1'b0;
      s_valid_6 = 1'b0;
      if (stall) begin
        @(posedge clk); #1;
      end
    end
    start = 1'b0;
  endtask

  task automatic wait_beats(input bit six, input int target);
    int g;
    g = 0;
    while ((six ? beats6 : beats4) < target && g < 300) begin
      @(posedge clk); #1;
      g++;
    end
    chk("beat_count", six ? beats6 : beats4, target);
    repeat (2) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic push4(input longint d0, input longint d1, input longint d2, input longint d3);
    q4.push_back('{d0, 1'b0});
    q4.push_back('{d1, 1'b0});
    q4.push_back('{d2, 1'b0});
    q4.push_back('{d3, 1'b1});
  endtask

  task automatic run4();
    int b0, d0;
    b0 = beats4;
    d0 = dones4;
    drive_cmd(0, 0, 0, 1);
    wait_beats(0, b0 + 4);
    chk("latency4", first4 - t0_4, 15);
    chk("done_count4", dones4 - d0, 1);
    chk("queue_empty4", q4.size(), 0);
    chk("valid_after4", m_valid, 0);
    chk("busy_after4", busy, 0);
  endtask

  initial begin
    int a0, b0, d0, g;
    longint sum;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_done", done, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_busy6", busy_6, 0);
    chk("rst_m_valid6", m_valid_6, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // load_matrix wins over start; identity A streamed with stalls while
    // a start pulse arrives mid-load.
    drive_cmd(0, 1, 0, 1);
    chk("prio_s_ready", s_ready, 1);
    chk("prio_busy", busy, 1);
    for (int i = 0; i < 16; i++) stim[i] = (i / 4 == i % 4) ? 1 : 0;
    a0 = accepted4;
    send(0, 16, 1, 1);
    chk("accepted_A", accepted4 - a0, 16);
    chk("s_ready_after_A", s_ready, 0);
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("start_ignored_busy", busy, 0);
    chk("start_ignored_valid", m_valid, 0);

    stim[0] = 1; stim[1] = -2; stim[2] = 3; stim[3] = -4;
    drive_cmd(0, 0, 1, 0);
    a0 = accepted4;
    send(0, 4, 0, 0);
    chk("accepted_x", accepted4 - a0, 4);
    chk("s_ready_after_x", s_ready, 0);

    // Identity run.
    m_ready = 1'b1;
    push4(1, -2, 3, -4);
    run4();

    // Backpressure: y[1] held for three cycles.
    push4(1, -2, 3, -4);
    m_ready = 1'b0;
    b0 = beats4;
    d0 = dones4;
    drive_cmd(0, 0, 0, 1);
    g = 0;
    while (!m_valid && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    chk("bp_valid_seen", m_valid, 1);
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_hold_y1", m_data, -2);
      chk("bp_hold_valid", m_valid, 1);
      @(posedge clk); #1;
    end
    m_ready = 1'b1;
    wait_beats(0, b0 + 4);
    chk("bp_latency", first4 - t0_4, 15);
    chk("bp_done_count", dones4 - d0, 1);
    chk("bp_queue_empty", q4.size(), 0);

    // Reset in the middle of COMPUTE, then rerun on retained storage.
    drive_cmd(0, 0, 0, 1);
    repeat (5) begin
      @(posedge clk); #1;
    end
    chk("midrun_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_s_ready", s_ready, 0);
    chk("arst_m_valid", m_valid, 0);
    chk("arst_m_last", m_last, 0);
    chk("arst_done", done, 0);
    chk("arst_m_data", m_data, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    push4(1, -2, 3, -4);
    run4();

    // Accumulator exceeds the output range.
    for (int i = 0; i < 16; i++) stim[i] = 127;
    drive_cmd(0, 1, 0, 0);
    send(0, 16, 0, 0);
    drive_cmd(0, 0, 1, 0);
    send(0, 4, 0, 0);
    push4(EXP_POS, EXP_POS, EXP_POS, EXP_POS);
    run4();
    for (int i = 0; i < 16; i++) stim[i] = -128;
    drive_cmd(0, 1, 0, 0);
    send(0, 16, 0, 0);
    push4(EXP_NEG, EXP_NEG, EXP_NEG, EXP_NEG);
    run4();

    // K=6, P=3 against the reference sum.
    for (int i = 0; i < 36; i++) a6[i] = int'($urandom_range(255)) - 128;
    for (int i = 0; i < 6; i++)  x6[i] = int'($urandom_range(255)) - 128;
    for (int i = 0; i < 36; i++) stim[i] = a6[i];
    drive_cmd(1, 1, 0, 0);
    a0 = accepted6;
    send(1, 36, 0, 0);
    chk("accepted_A6", accepted6 - a0, 36);
    for (int i = 0; i < 6; i++) stim[i] = x6[i];
    drive_cmd(1, 0, 1, 0);
    send(1, 6, 0, 0);
    for (int r = 0; r < 6; r++) begin
      sum = 0;
      for (int c = 0; c < 6; c++) sum += longint'(a6[r * 6 + c]) * longint'(x6[c]);
      q6.push_back('{conv16(sum), (r == 5)});
    end
    b0 = beats6;
    d0 = dones6;
    drive_cmd(1, 0, 0, 1);
    wait_beats(1, b0 + 6);
    chk("latency6", first6 - t0_6, 19);
    chk("done_count6", dones6 - d0, 1);
    chk("queue_empty6", q6.size(), 0);
    chk("busy_after6", busy_6, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test by time %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mvm_lanes.md
Name: mvm_lanes

Overview:
- Parametrised signed matrix-vector multiplier: y = A·x, with A a K×K matrix and x a K-vector.
- P parallel MAC lanes compute P rows per pass.
- A and x are loaded over a valid/ready input stream; y is returned over a valid/ready output stream with backpressure.
- Next-generation datapath for the accelerator: multi-lane, stream handshakes, width-managed output.

Parameters:
- K, 8: matrix/vector dimension. Must be ≥2 and divisible by P.
- P, 2: number of MAC lanes. Must be ≥1 and divide K.
- B, 8: signed input element width.
- OUT_W, 16: signed output width. Must satisfy B+1 ≤ OUT_W ≤ ACC_W.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- load_matrix  input  1  command: load A (sampled only in IDLE)
- load_vector  input  1  command: load x (sampled only in IDLE)
- start  input  1  command: compute y (sampled only in IDLE)
- s_valid  input  1  input stream beat valid
- s_ready  output  1  input stream ready
- s_data  input  B  signed input element
- m_valid  output  1  output stream beat valid
- m_ready  input  1  output stream ready
- m_data  output  OUT_W  signed y element
- m_last  output  1  marks y[K-1]
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse when the y[K-1] beat is accepted

Behaviour:
- Clocking and reset:
  - Single clock; reset is asynchronous and active-high.
  - On reset: state=IDLE; s_ready, m_valid, m_last, busy, done all 0; m_data=0; counters cleared.
  - A, x and y storage contents are not cleared by reset.
- Derived width: ACC_W = 2B + clog2(K). Accumulation is full precision and never overflows.
- States: IDLE, LOAD_A, LOAD_X, COMPUTE, OUTPUT.
- IDLE:
  - Command priority when several are high: load_matrix > load_vector > start.
  - Commands in any other state are ignored.
- LOAD_A:
  - s_ready=1. Each beat (s_valid && s_ready) writes the next A element in row-major order.
  - Row r is stored in lane bank r mod P.
  - After K*K beats: s_ready drops in the same cycle the last beat is accepted; next state is IDLE.
  - s_valid low stalls the load with no timeout.
- LOAD_X: same as LOAD_A with K beats into x storage.
- s_ready=0 outside LOAD_A/LOAD_X; s_data is ignored there.
- COMPUTE: K/P passes; pass g covers rows g*P .. g*P+P-1.
  - Per pass: K address-issue cycles.
  - 1-cycle memory read, 1-cycle product register, 1-cycle accumulate; the final accumulate completes by the end of the K+2nd cycle of the pass.
  - Accumulators are cleared at each pass start.
  - The pass ends with a P-result writeback cycle; each pass is exactly K+3 cycles.
- Latency: with start sampled high at edge 0, m_valid first rises after edge (K/P)*(K+3)+1.
- OUTPUT:
  - Streams y[0]..y[K-1] in order; m_last=1 only with y[K-1].
  - While m_valid && !m_ready, m_data and m_last hold stable.
  - On acceptance of y[K-1]: m_valid=0, done=1 for one cycle, state returns to IDLE.
- Output conversion without saturation: m_data = low OUT_W bits of the accumulator (two's-complement wrap).
- start without prior loads computes on current storage contents. Storage is undefined after power-up; reloading is not required between starts.
- Reset mid-operation: immediate return to IDLE. A partially loaded A or x keeps the beats already written.

Optional Feature:
- Macro: MVM_SAT_EN.
- Defined: the ACC_W→OUT_W conversion saturates to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Not defined: the conversion truncates (wraps).
- Latency and handshakes are identical in both builds.

Test Plan:
- All scenarios use K=4, P=2, B=8, OUT_W=16 unless stated.
- Identity + vector: A=I, x=[1,-2,3,-4], m_ready=1 → m_data 1,-2,3,-4; m_last on 4th beat; done once; first m_valid 15 cycles after start.
- Overflow: A all 127, x all 127 (sum 64516) → m_data -1020 without MVM_SAT_EN, 32767 with it. A all -128, x all 127 → -32768 with MVM_SAT_EN.
- Backpressure: m_ready=0 for 3 cycles while y[1] is presented → m_data constant across those cycles; no beat lost or duplicated; total 4 beats.
- Load stalls and busy commands:
  - s_valid toggled 1/0 during LOAD_A → exactly 16 elements accepted; s_ready=0 afterwards.
  - start pulsed during LOAD_A → ignored; busy=1 throughout.
- Priority and reset: load_matrix and start high together in IDLE → LOAD_A entered. Reset asserted mid-COMPUTE → all outputs 0 and busy=0 at once; a following start with no reload gives correct y from the retained A and x.
- Lane generality: K=6, P=3 with random A and x → y matches the reference model; first m_valid at cycle 2*9+1=19.
